// File: rtl/bus_master_arb.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | bus_master_arb: 4-master round-robin arbiter onto one shared slave bus  |
// | with a bounded ready wait and a one-cycle abort.         Revision: 1.0  |
// +-------------------------------------------------------------------------+
module bus_master_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [3:0]   m_csn,
  input  logic [3:0]   m_wen,
  input  logic [127:0] m_addr,
  input  logic [127:0] m_wdata,
  output logic [127:0] m_rdata,
  output logic [3:0]   m_rdyn,
  output logic         b_csn,
  output logic         b_wen,
  output logic [31:0]  b_addr,
  output logic [31:0]  b_wdata,
  input  logic [31:0]  b_rdata,
  input  logic         b_rdyn,
  output logic [3:0]   gnt,
  output logic         err,
  output logic [1:0]   err_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     gnt_q, gnt_d;
  logic [1:0]     last_q, last_d;
  logic [1:0]     idx_q, idx_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           b_csn_q, b_csn_d;
  logic           b_wen_q, b_wen_d;
  logic [31:0]    b_addr_q, b_addr_d;
  logic [31:0]    b_wdata_q, b_wdata_d;
  logic [127:0]   rdata_q, rdata_d;
  logic           err_q, err_d;
  logic [1:0]     err_id_q, err_id_d;

  logic           win_found;
  logic [1:0]     win_idx;
  logic [1:0]     cand;
  logic           done;

  // Round-robin search starting one past the previous owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k < 5; k++) begin
      cand = last_q + 2'(k);
      if (!win_found && !m_csn[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign done = (state_q == BUSY) && !b_rdyn;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    b_csn_d   = b_csn_q;
    b_wen_d   = b_wen_q;
    b_addr_d  = b_addr_q;
    b_wdata_d = b_wdata_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    err_id_d  = err_id_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d   = BUSY;
          gnt_d     = 4'b0001 << win_idx;
          idx_d     = win_idx;
          last_d    = win_idx;
          cnt_d     = 8'd0;
          b_csn_d   = 1'b0;
          b_wen_d   = m_wen[win_idx];
          b_addr_d  = m_addr[{win_idx, 5'd0} +: 32];
          b_wdata_d = m_wdata[{win_idx, 5'd0} +: 32];
        end
      end
      BUSY: begin
        // Ready wins over a timeout landing on the same cycle.
        if (!b_rdyn) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          b_csn_d = 1'b1;
          rdata_d[{idx_q, 5'd0} +: 32] = b_rdata;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d  = ABORT;
          b_csn_d  = 1'b1;
          rdata_d[{idx_q, 5'd0} +: 32] = 32'h0;
          err_d    = 1'b1;
          err_id_d = idx_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ABORT: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        b_csn_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      last_q    <= 2'd3;
      idx_q     <= 2'd0;
      cnt_q     <= 8'd0;
      b_csn_q   <= 1'b1;
      b_wen_q   <= 1'b1;
      b_addr_q  <= 32'h0;
      b_wdata_q <= 32'h0;
      rdata_q   <= 128'h0;
      err_q     <= 1'b0;
      err_id_q  <= 2'd0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      b_csn_q   <= b_csn_d;
      b_wen_q   <= b_wen_d;
      b_addr_q  <= b_addr_d;
      b_wdata_q <= b_wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_id_q  <= err_id_d;
    end
  end

  // The completing master sees the slave data in the ready cycle itself.
  always_comb begin
    m_rdata = rdata_q;
    if (done) m_rdata[{idx_q, 5'd0} +: 32] = b_rdata;
  end

  assign m_rdyn  = ~(gnt_q & {4{done | (state_q == ABORT)}});
  assign gnt     = gnt_q;
  assign b_csn   = b_csn_q;
  assign b_wen   = b_wen_q;
  assign b_addr  = b_addr_q;
  assign b_wdata = b_wdata_q;
  assign err     = err_q;
  assign err_id  = err_id_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_master_arb.sv
`default_nettype none
// Testbench for bus_master_arb: directed scenarios plus random traffic
// compared every cycle against a transaction-level model.
module tb_bus_master_arb;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic [3:0]   m_csn, m_wen, m_rdyn, gnt;
  logic [127:0] m_addr, m_wdata, m_rdata;
  logic         b_csn, b_wen, b_rdyn, err;
  logic [31:0]  b_addr, b_wdata, b_rdata;
  logic [1:0]   err_id;

  int checks = 0;
  int errors = 0;

  bus_master_arb #(.TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .m_csn(m_csn), .m_wen(m_wen), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_rdyn(m_rdyn), .b_csn(b_csn),
    .b_wen(b_wen), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata),
    .b_rdyn(b_rdyn), .gnt(gnt), .err(err), .err_id(err_id)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = no owner, 1 = owner waiting for ready, 2 = abort cycle.
  int          ph, own, last, waited, e_err_id;
  logic [31:0] e_addr, e_wdata;
  logic        e_wen;
  logic [31:0] e_rd [4];

  function automatic void model_reset();
    ph = 0; own = 0; last = 3; waited = 0; e_err_id = 0;
    e_addr = 0; e_wdata = 0; e_wen = 1'b1;
    for (int i = 0; i < 4; i++) e_rd[i] = 32'h0;
  endfunction

  function automatic void model_edge();
    if (ph == 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (last + k) % 4;
        if (ph == 0 && m_csn[c] == 1'b0) begin
          ph = 1; own = c; last = c; waited = 0;
          e_addr  = m_addr[32*c +: 32];
          e_wdata = m_wdata[32*c +: 32];
          e_wen   = m_wen[c];
        end
      end
    end else if (ph == 1) begin
      if (!b_rdyn) begin
        e_rd[own] = b_rdata;
        ph = 0;
      end else begin
        waited++;
        if (waited == TO) begin
          e_rd[own] = 32'h0;
          e_err_id  = own;
          ph = 2;
        end
      end
    end else begin
      ph = 0;
    end
  endfunction

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [3:0]   x_rdyn, x_gnt;
    logic [127:0] x_rdata;
    logic         fin;
    #1;
    fin    = (ph == 1) && !b_rdyn;
    x_gnt  = (ph == 0) ? 4'h0 : 4'(1 << own);
    x_rdyn = 4'hF;
    if (fin || ph == 2) x_rdyn[own] = 1'b0;
    for (int i = 0; i < 4; i++)
      x_rdata[32*i +: 32] = (fin && i == own) ? b_rdata : e_rd[i];
    cmp("b_csn",   128'(b_csn),   128'(ph != 1));
    cmp("b_wen",   128'(b_wen),   128'(e_wen));
    cmp("b_addr",  128'(b_addr),  128'(e_addr));
    cmp("b_wdata", 128'(b_wdata), 128'(e_wdata));
    cmp("gnt",     128'(gnt),     128'(x_gnt));
    cmp("err",     128'(err),     128'(ph == 2));
    cmp("err_id",  128'(err_id),  128'(e_err_id));
    cmp("m_rdyn",  128'(m_rdyn),  128'(x_rdyn));
    cmp("m_rdata", m_rdata,       x_rdata);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  logic [3:0] rr_exp [10];

  initial begin
    rr_exp = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};
    rstn = 1'b0; m_csn = 4'hF; m_wen = 4'hF; m_addr = '0; m_wdata = '0;
    b_rdata = 32'h0; b_rdyn = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    compare();
    cmp("rst_b_csn", 128'(b_csn), 128'(1'b1));
    cmp("rst_b_wen", 128'(b_wen), 128'(1'b1));
    cmp("rst_gnt", 128'(gnt), 128'(4'h0));
    cmp("rst_m_rdyn", 128'(m_rdyn), 128'(4'hF));
    cmp("rst_m_rdata", m_rdata, 128'h0);
    cmp("rst_err", 128'(err), 128'(1'b0));

    // All masters request continuously, slave ready immediately.
    m_csn = 4'h0; b_rdyn = 1'b0; b_rdata = 32'hCAFE0000;
    for (int i = 0; i < 10; i++) begin
      adv();
      compare();
      cmp($sformatf("rr_gnt%0d", i), 128'(gnt), 128'(rr_exp[i]));
    end
    m_csn = 4'hF; b_rdyn = 1'b1;

    // Single read by master 0, ready on the second bus cycle.
    m_csn = 4'b1110; m_addr[31:0] = 32'h100; m_wen = 4'hF;
    adv(); compare();
    cmp("rd_b_addr", 128'(b_addr), 128'h100);
    cmp("rd_b_wen", 128'(b_wen), 128'(1'b1));
    cmp("rd_gnt", 128'(gnt), 128'(4'h1));
    adv(); b_rdyn = 1'b0; b_rdata = 32'hA5A5A5A5; compare();
    cmp("rd_m_rdyn", 128'(m_rdyn), 128'(4'b1110));
    cmp("rd_m_rdata_comb", 128'(m_rdata[31:0]), 128'h A5A5A5A5);
    adv(); m_csn = 4'hF; b_rdyn = 1'b1; b_rdata = 32'h0; compare();
    cmp("rd_m_rdyn_after", 128'(m_rdyn), 128'(4'hF));
    cmp("rd_m_rdata_held", 128'(m_rdata[31:0]), 128'hA5A5A5A5);

    // Write by master 2; master inputs churn and withdraw during the access.
    m_csn = 4'b1011; m_wen = 4'b1011; m_wdata[95:64] = 32'h12345678;
    m_addr[95:64] = 32'h2000;
    adv();
    for (int i = 0; i < 3; i++) begin
      m_wdata = {$urandom, $urandom, $urandom, $urandom};
      m_wen = 4'hF; m_csn = 4'hF;
      compare();
      cmp("wr_b_wen", 128'(b_wen), 128'(1'b0));
      cmp("wr_b_wdata", 128'(b_wdata), 128'h12345678);
      cmp("wr_b_addr", 128'(b_addr), 128'h2000);
      adv();
    end
    b_rdyn = 1'b0; compare();
    cmp("wr_m_rdyn", 128'(m_rdyn), 128'(4'b1011));
    adv(); b_rdyn = 1'b1; compare();

    // Timeout on master 3.
    m_csn = 4'b0111;
    adv();
    for (int i = 0; i < TO; i++) begin
      compare();
      cmp("to_b_csn", 128'(b_csn), 128'(1'b0));
      cmp("to_err_early", 128'(err), 128'(1'b0));
      adv();
    end
    m_csn = 4'hF; compare();
    cmp("to_err", 128'(err), 128'(1'b1));
    cmp("to_err_id", 128'(err_id), 128'(2'd3));
    cmp("to_m_rdyn", 128'(m_rdyn), 128'(4'b0111));
    cmp("to_m_rdata", 128'(m_rdata[127:96]), 128'h0);
    cmp("to_b_csn_abort", 128'(b_csn), 128'(1'b1));
    cmp("to_gnt", 128'(gnt), 128'(4'h8));
    adv(); compare();
    cmp("to_err_pulse", 128'(err), 128'(1'b0));
    cmp("to_err_id_hold", 128'(err_id), 128'(2'd3));

    // Master 1: ready arrives on the last allowed bus cycle.
    m_csn = 4'b1101;
    adv();
    for (int i = 0; i < TO - 1; i++) begin
      compare();
      adv();
    end
    b_rdyn = 1'b0; b_rdata = 32'h5EED0001; m_csn = 4'hF; compare();
    cmp("rt_m_rdyn", 128'(m_rdyn), 128'(4'b1101));
    cmp("rt_err", 128'(err), 128'(1'b0));
    adv(); b_rdyn = 1'b1; compare();
    cmp("rt_err_after", 128'(err), 128'(1'b0));
    cmp("rt_m_rdata", 128'(m_rdata[63:32]), 128'h5EED0001);
    cmp("rt_b_csn", 128'(b_csn), 128'(1'b1));

    // Reset in the middle of a master 2 access.
    m_csn = 4'b1011;
    adv(); m_csn = 4'hF; compare();
    #2 rstn = 1'b0;
    #1;
    cmp("ar_b_csn", 128'(b_csn), 128'(1'b1));
    cmp("ar_gnt", 128'(gnt), 128'(4'h0));
    cmp("ar_m_rdyn", 128'(m_rdyn), 128'(4'hF));
    cmp("ar_m_rdata", m_rdata, 128'h0);
    cmp("ar_b_addr", 128'(b_addr), 128'h0);
    cmp("ar_err_id", 128'(err_id), 128'(2'd0));
    model_reset();
    @(posedge clk);
    #1 rstn = 1'b1; m_csn = 4'h0;
    compare();
    adv(); compare();
    cmp("ar_next_gnt", 128'(gnt), 128'(4'h1));
    m_csn = 4'hF;

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      adv();
      m_csn   = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      m_wen   = 4'($urandom);
      m_addr  = {$urandom, $urandom, $urandom, $urandom};
      m_wdata = {$urandom, $urandom, $urandom, $urandom};
      b_rdyn  = ($urandom_range(0, 2) != 0);
      b_rdata = $urandom;
      compare();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
